instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_if.sv | 25 ++
 rtl/instr_fetch_queue.sv | 99 +++++++++
 tb/tb_instr_fetch_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: control and redirect inputs, instruction memory port,
// head-of-queue outputs and event counters.
interface instr_fetch_queue_if;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    modport slave (
        input  start_i, redirect_i, redirect_pc_i, imem_data_i, stall_i,
        output imem_addr_o, valid_o, instr_o, pc_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output start_i, redirect_i, redirect_pc_i, imem_data_i, stall_i,
        input  imem_addr_o, valid_o, instr_o, pc_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential fetch into a circular {pc,instr} buffer,
// drained by decode, flushed on redirect.
//
//   state | meaning
//   IDLE  | no fetches issued; queued entries still drain
//   RUN   | one fetch per cycle while the queue has room
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk_i,
    input logic          rst_i,
    instr_fetch_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [15:0]   stall_cnt, flush_cnt;

    logic valid, full, push, pop, stall_event;

    assign valid       = (count != '0);
    assign full        = (count == FULL_CNT);
    assign push        = (state_q == RUN) && !bus.redirect_i && !full;
    assign pop         = valid && !bus.stall_i && !bus.redirect_i;
    assign stall_event = valid && bus.stall_i && !bus.redirect_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i)  state_d = RUN;
            RUN:     if (!bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never reset; count/pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[tail]    <= fetch_pc;
            mem_instr[tail] <= bus.imem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_event && stall_cnt != 16'hFFFF)    stall_cnt <= stall_cnt + 16'd1;
            if (bus.redirect_i && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.imem_addr_o = fetch_pc;
    assign bus.valid_o     = valid;
    assign bus.instr_o     = valid ? mem_instr[head] : 32'h0;
    assign bus.pc_o        = valid ? mem_pc[head]    : 32'h0;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed phases push expected pops into a
// scoreboard queue; a negedge monitor pops and compares every dequeue.
module tb_instr_fetch_queue;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus();
    assign bus.imem_data_i = (bus.imem_addr_o >> 2) + 32'd1;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic [31:0] exp_pc [$];
    logic [31:0] mon_pc;
    logic [31:0] head_pc;
    logic [31:0] held_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_stream(input logic [31:0] start_pc);
        exp_pc.delete();
        for (int i = 0; i < 64; i++) exp_pc.push_back(start_pc + 32'(4 * i));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.valid_o && !bus.stall_i && !bus.redirect_i) begin
            pops++;
            if (exp_pc.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: actual pc=%h required=none", bus.pc_o);
            end else begin
                mon_pc = exp_pc.pop_front();
                check("pop_pc", bus.pc_o, mon_pc);
                check("pop_instr", bus.instr_o, (mon_pc >> 2) + 32'd1);
            end
        end
    end

    initial begin
        bus.start_i       = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        #2;
        check("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_imem_addr", bus.imem_addr_o, 32'h0);
        check("rst_stall_cnt", {16'b0, bus.stall_cnt_o}, 32'h0);
        check("rst_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'h0);

        // Streaming from reset
        push_stream(32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.start_i = 1'b1;
        pops        = 0;
        step(10);
        check("stream_pops_ge6", {31'b0, pops >= 6}, 32'h1);

        // Stall six cycles: queue fills, head and fetch address freeze
        head_pc     = bus.pc_o;
        bus.stall_i = 1'b1;
        step(6);
        check("stall_cnt_6", {16'b0, bus.stall_cnt_o}, 32'd6);
        check("stall_head_pc", bus.pc_o, head_pc);
        check("stall_valid", {31'b0, bus.valid_o}, 32'h1);
        check("stall_imem_addr", bus.imem_addr_o, head_pc + 32'd16);
        bus.stall_i = 1'b0;
        pops        = 0;
        step(8);
        check("drain_pops_ge6", {31'b0, pops >= 6}, 32'h1);

        // Redirect to 0x40 with three entries queued
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        push_stream(32'h40);
        step(1);
        check("redir_valid", {31'b0, bus.valid_o}, 32'h0);
        check("redir_instr", bus.instr_o, 32'h0);
        check("redir_pc", bus.pc_o, 32'h0);
        check("redir_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'd1);
        check("redir_stall_cnt", {16'b0, bus.stall_cnt_o}, 32'd6);
        bus.redirect_i = 1'b0;
        pops           = 0;
        step(6);
        check("redir_pops_ge3", {31'b0, pops >= 3}, 32'h1);

        // Redirect together with stall: flush wins, no stall count
        bus.stall_i = 1'b1;
        step(1);
        check("pre_flush_stall_cnt", {16'b0, bus.stall_cnt_o}, 32'd7);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        push_stream(32'h100);
        step(1);
        check("flushstall_stall_cnt", {16'b0, bus.stall_cnt_o}, 32'd7);
        check("flushstall_valid", {31'b0, bus.valid_o}, 32'h0);
        check("flushstall_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'd2);
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        pops           = 0;
        step(6);
        check("flushstall_pops_ge3", {31'b0, pops >= 3}, 32'h1);

        // Redirect near top of address space; low bits ignored, pc wraps
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        push_stream(32'hFFFF_FFFC);
        step(1);
        check("wrap_imem_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        check("wrap_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'd3);
        bus.redirect_i = 1'b0;
        pops           = 0;
        step(6);
        check("wrap_pops_ge3", {31'b0, pops >= 3}, 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        exp_pc.delete();
        #1;
        check("areset_valid", {31'b0, bus.valid_o}, 32'h0);
        check("areset_instr", bus.instr_o, 32'h0);
        check("areset_pc", bus.pc_o, 32'h0);
        check("areset_imem_addr", bus.imem_addr_o, 32'h0);
        check("areset_stall_cnt", {16'b0, bus.stall_cnt_o}, 32'h0);
        check("areset_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'h0);
        push_stream(32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pops  = 0;
        step(8);
        check("restart_pops_ge4", {31'b0, pops >= 4}, 32'h1);
        check("restart_flush_cnt", {16'b0, bus.flush_cnt_o}, 32'h0);

        // Stop fetching: queue drains, fetch address holds
        bus.start_i = 1'b0;
        step(8);
        check("idle_valid", {31'b0, bus.valid_o}, 32'h0);
        held_addr = bus.imem_addr_o;
        step(3);
        check("idle_imem_hold", bus.imem_addr_o, held_addr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
